seq_detector_param: RTL and testbench

Parametrised serial sequence detector. It is the next generation of the lab's fixed eight-state pattern detector. Pattern, length and don't-care mask are programmable at run time. The block adds an input-valid strobe, an overlap / non-overlap mode and a saturating match counter. It sits directly behind a serial bit source (switch debouncer or shift-out block) and drives a match LED/pulse plus a count display.

---
 rtl/seq_det_pkg.sv | 27 ++
 rtl/sat_counter.sv | 21 ++
 rtl/seq_detector_param.sv | 100 ++++++++++
 tb/tb_seq_detector_param.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types, defaults and helpers for the programmable serial sequence detector.
package seq_det_pkg;

  localparam int MAX_W = 32;
  localparam int DEFAULT_LEN = 8;
  localparam logic [7:0] DEFAULT_PAT = 8'b0010_0011;

  typedef enum logic [0:0] {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } state_e;

  // A zero length would make every bit a match, so it is treated as one bit.
  function automatic int len_clamp(input int len_in, input int w = DEFAULT_LEN);
    if (len_in < 1) return 1;
    if (len_in > w) return w;
    return len_in;
  endfunction

  function automatic logic [MAX_W-1:0] len_mask(input int len);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) m[i] = (i < len);
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and clear.
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Programmable serial sequence detector: run-time pattern/mask/length, valid strobe,
// overlap mode and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int           W        = DEFAULT_LEN,
  parameter int           CW       = 8,
  parameter logic [W-1:0] DEF_PAT  = W'(DEFAULT_PAT),
  parameter logic [W-1:0] DEF_MASK = '1,
  parameter int           DEF_LEN  = W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     x,
  input  logic                     x_valid,
  input  logic                     overlap,
  input  logic                     pat_load,
  input  logic [W-1:0]             pat_in,
  input  logic [W-1:0]             mask_in,
  input  logic [$clog2(W+1)-1:0]   len_in,
  input  logic                     cnt_clr,
  output logic                     z,
  output logic [CW-1:0]            match_count,
  output logic [$clog2(W+1)-1:0]   fill
);

  localparam int LW = $clog2(W+1);
  localparam logic [LW-1:0] FULL = LW'(W);

  logic [W-1:0]  hist;
  logic [W-1:0]  pat;
  logic [W-1:0]  mask;
  logic [LW-1:0] len;
  state_e        state;
  state_e        state_n;

  logic [W-1:0]  hist_n;
  logic [LW-1:0] fill_n;
  logic [W-1:0]  lmask;
  logic          in_range;
  logic          hit;

  assign hist_n   = {hist[W-2:0], x};
  assign fill_n   = (fill == FULL) ? FULL : fill + 1'b1;
  assign lmask    = W'(len_mask(int'(len)));
  assign in_range = (fill_n >= len);
  // Bits outside the active length or masked off never block a match.
  assign hit      = x_valid && !pat_load && in_range &&
                    (((hist_n ^ pat) & mask & lmask) == '0);

  // The phase bit mirrors fill >= len; it only leaves ARMED via a restart.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_n unassigned (avoids a latch).
    state_n = state;
    if (pat_load) begin
      state_n = FILLING;
    end else if (x_valid) begin
      if (hit && !overlap) state_n = FILLING;
      else if (in_range)   state_n = ARMED;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the history is reset because a restart must never see stale bits.
      hist  <= '0;
      fill  <= '0;
      z     <= 1'b0;
      pat   <= DEF_PAT;
      mask  <= DEF_MASK;
      len   <= LW'(len_clamp(DEF_LEN, W));
      state <= FILLING;
    end else if (pat_load) begin
      pat   <= pat_in;
      mask  <= mask_in;
      len   <= LW'(len_clamp(int'(len_in), W));
      hist  <= '0;
      fill  <= '0;
      z     <= 1'b0;
      state <= state_n;
    end else begin
      z     <= hit;
      state <= state_n;
      if (x_valid) begin
        hist <= hist_n;
        // Non-overlap keeps the history bits but forgets how many are usable.
        fill <= (hit && !overlap) ? '0 : fill_n;
      end
    end
  end

  sat_counter #(.CW(CW)) u_count (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (hit),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed and randomized checks of seq_detector_param against a queue-based reference model.
module tb_seq_detector_param;

  localparam int W    = 8;
  localparam int CW   = 2;
  localparam int LW   = 4;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          x;
  logic          x_valid;
  logic          overlap;
  logic          pat_load;
  logic [W-1:0]  pat_in;
  logic [W-1:0]  mask_in;
  logic [LW-1:0] len_in;
  logic          cnt_clr;
  logic          z;
  logic [CW-1:0] match_count;
  logic [LW-1:0] fill;

  always #5 clk = ~clk;

  seq_detector_param #(.W(W), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .x_valid     (x_valid),
    .overlap     (overlap),
    .pat_load    (pat_load),
    .pat_in      (pat_in),
    .mask_in     (mask_in),
    .len_in      (len_in),
    .cnt_clr     (cnt_clr),
    .z           (z),
    .match_count (match_count),
    .fill        (fill)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: received bits as a queue, plus count of bits since the last restart.
  logic [W-1:0] m_pat;
  logic [W-1:0] m_mask;
  int           m_len;
  int           m_since;
  int           m_cnt;
  bit           m_z;
  bit           m_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pat   = 8'b0010_0011;
    m_mask  = '1;
    m_len   = W;
    m_since = 0;
    m_cnt   = 0;
    m_z     = 1'b0;
    m_q.delete();
  endtask

  // Latest bit pairs with pattern bit 0, the one before with bit 1, and so on.
  function automatic bit model_cmp();
    for (int k = 0; k < m_len; k++) begin
      if (m_mask[k] && (m_q[m_q.size()-1-k] != m_pat[k])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic tick();
    bit hit;
    @(posedge clk);
    hit = 1'b0;
    if (pat_load) begin
      m_pat   = pat_in;
      m_mask  = mask_in;
      m_len   = (len_in == 0) ? 1 : ((int'(len_in) > W) ? W : int'(len_in));
      m_since = 0;
      m_q.delete();
    end else if (x_valid) begin
      m_q.push_back(x);
      if (m_q.size() > W) void'(m_q.pop_front());
      m_since++;
      hit = (m_since >= m_len) && model_cmp();
      if (hit && !overlap) m_since = 0;
    end
    m_z = hit;
    if (cnt_clr)                 m_cnt = 0;
    else if (hit && m_cnt < CMAX) m_cnt++;
    #1;
    chk("z", z, m_z);
    chk("count", match_count, m_cnt);
    chk("fill", fill, (m_since > W) ? W : m_since);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    chk("rst_z", z, 0);
    chk("rst_fill", fill, 0);
    chk("rst_count", match_count, 0);
    reset = 1'b1;
  endtask

  task automatic send(input bit b);
    x       = b;
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i]);
  endtask

  task automatic load(input logic [W-1:0] p, input logic [W-1:0] m, input logic [LW-1:0] l);
    pat_load = 1'b1;
    pat_in   = p;
    mask_in  = m;
    len_in   = l;
    tick();
    pat_load = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    x        = 1'b0;
    x_valid  = 1'b0;
    overlap  = 1'b1;
    pat_load = 1'b0;
    pat_in   = '0;
    mask_in  = '0;
    len_in   = '0;
    cnt_clr  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Default pattern after reset
    do_reset();
    send_bits(32'b0010_0011, 8);
    chk("def_z", z, 1);
    chk("def_count", match_count, 1);
    chk("def_fill", fill, 8);
    send(1'b0);
    chk("def_z_drop", z, 0);

    // Overlapping matches of 0101
    do_reset();
    overlap = 1'b1;
    load(8'b0101, 8'h0F, 4'd4);
    send_bits(32'b0101010, 7);
    chk("ovl_count", match_count, 2);

    // Non-overlapping: one match, fill restarts
    do_reset();
    overlap = 1'b0;
    load(8'b0101, 8'h0F, 4'd4);
    send_bits(32'b0101, 4);
    chk("novl_z", z, 1);
    chk("novl_fill0", fill, 0);
    send_bits(32'b010, 3);
    chk("novl_count", match_count, 1);
    chk("novl_fill3", fill, 3);

    // Don't-care middle bits with idle gaps
    load(8'b1001, 8'b1001, 4'd4);
    for (int i = 0; i < 4; i++) begin
      send(1'b1);
      if (i < 3) begin
        tick();
        tick();
        chk("gap_z", z, 0);
        chk("gap_fill", fill, i + 1);
      end
    end
    chk("mask_z", z, 1);

    // Saturation and clear priority
    do_reset();
    overlap = 1'b1;
    load(8'h01, 8'h01, 4'd1);
    repeat (5) send(1'b1);
    chk("sat_count", match_count, 3);
    cnt_clr = 1'b1;
    send(1'b1);
    cnt_clr = 1'b0;
    chk("clr_count", match_count, 0);
    chk("clr_z", z, 1);

    // Load drops a simultaneous bit
    x        = 1'b1;
    x_valid  = 1'b1;
    pat_load = 1'b1;
    pat_in   = 8'b0101;
    mask_in  = 8'h0F;
    len_in   = 4'd4;
    tick();
    pat_load = 1'b0;
    x_valid  = 1'b0;
    chk("ldprio_fill", fill, 0);

    // Reset while armed restores defaults
    send_bits(32'b0101, 4);
    chk("armed_fill", fill, 4);
    do_reset();
    send_bits(32'b0010_0011, 8);
    chk("rst_defpat_z", z, 1);

    // Zero length behaves as one bit
    load(8'h01, 8'hFF, 4'd0);
    send(1'b0);
    chk("len0_miss", z, 0);
    send(1'b1);
    chk("len0_hit", z, 1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      pat_load = ($urandom_range(0, 39) == 0);
      if (pat_load) begin
        pat_in  = W'($urandom);
        mask_in = W'($urandom);
        len_in  = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom_range(0, 5));
      end
      x       = 1'($urandom);
      x_valid = ($urandom_range(0, 3) != 0);
      overlap = 1'($urandom);
      cnt_clr = ($urandom_range(0, 29) == 0);
      tick();
    end
    pat_load = 1'b0;
    x_valid  = 1'b0;
    cnt_clr  = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
